seq_mult_param: RTL

- Parametrised shift-and-add sequential multiplier; next generation of the team's 8-bit control/datapath multiplier.
- Generalised to any operand width.
- Adds a start/busy/done handshake, a held product register and one-iteration-per-clock operation.
- Sits as a datapath slave behind a controller that issues operands and waits for done.

---
 rtl/seq_mult_param_if.sv | 37 +++
 rtl/seq_mult_param.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_mult_param_if.sv
// rtl/seq_mult_param_if.sv - start/busy/done operand and result bundle for seq_mult_param (optional tc under SEQ_MULT_SIGNED_EN)
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                 start;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [CW-1:0]        count;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 tc;

    modport master (
        output start, mcand, mplier, tc,
        input  busy, done, product, count
    );

    modport slave (
        input  start, mcand, mplier, tc,
        output busy, done, product, count
    );
`else
    modport master (
        output start, mcand, mplier,
        input  busy, done, product, count
    );

    modport slave (
        input  start, mcand, mplier,
        output busy, done, product, count
    );
`endif
endinterface

// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - shift-and-add sequential multiplier, one iteration per clock; SEQ_MULT_SIGNED_EN adds two's-complement mode
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic         CLK,
    input  logic         Clr,
    seq_mult_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     b_q;
    logic [CW-1:0]        p_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 done_q;

    logic                 load;
    logic                 iter;
    logic                 last;
    logic                 signed_mode;
    logic                 ext_a;
    logic                 ext_b;
    logic [WIDTH:0]       addend;
    logic [WIDTH:0]       sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic                 tc_q;

    // Mode flag captured alongside the operands so it cannot change mid-operation
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            tc_q <= 1'b0;
        end else if (load) begin
            tc_q <= bus.tc;
        end
    end

    assign signed_mode = tc_q;
`else
    assign signed_mode = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; the done cycle is spent in IDLE so start is accepted back-to-back
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        iter    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                iter = 1'b1;
                if (p_q == CW'(1)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Partial sum one bit wider than A so the carry (or sign) survives into the shift
    always_comb begin
        ext_a  = signed_mode & a_q[WIDTH-1];
        ext_b  = signed_mode & b_q[WIDTH-1];
        addend = {ext_b, b_q};
        if (!q_q[0]) begin
            sum = {ext_a, a_q};
        end else if (signed_mode && last) begin
            // the multiplier's sign bit carries negative weight
            sum = {ext_a, a_q} - addend;
        end else begin
            sum = {ext_a, a_q} + addend;
        end
    end

    // Operand capture, shift of the sum/Q chain, iteration count and held product
    always_ff @(posedge CLK or negedge Clr) begin
        if (!Clr) begin
            a_q    <= '0;
            q_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            prod_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (load) begin
                b_q <= bus.mcand;
                q_q <= bus.mplier;
                a_q <= '0;
                p_q <= CW'(WIDTH);
            end else if (iter) begin
                a_q <= sum[WIDTH:1];
                q_q <= {sum[0], q_q[WIDTH-1:1]};
                p_q <= p_q - CW'(1);
                if (last) begin
                    prod_q <= {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                end
            end
        end
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.done    = done_q;
    assign bus.product = prod_q;
    assign bus.count   = p_q;

endmodule
